// File: rtl/mem_port_b_arbiter.sv
// mem_port_b_arbiter: round-robin, burst-bounded sharing of RAM port B between R0 (display) and R1 (DMA)
module mem_port_b_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_b_addr,
    output logic [DATA_W-1:0] mem_b_wdata,
    output logic              mem_b_we,
    input  logic [DATA_W-1:0] mem_b_rdata
);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic          owner, last, rpend0, rpend1;
    logic [BW-1:0] beats;
    logic          own_req, oth_req, keep, both;

    always_comb begin
        own_req = owner ? r1_req : r0_req;
        oth_req = owner ? r0_req : r1_req;
        keep    = own_req && (beats < BW'(MAX_BURST) || !oth_req);
        both    = r0_req && r1_req;
        r0_gnt  = !reset && (keep ? !owner : both ? last : r0_req && !r1_req);
        r1_gnt  = !reset && (keep ? owner : both ? !last : r1_req && !r0_req);
    end

    assign mem_b_we    = r0_gnt ? r0_we : r1_gnt ? r1_we : 1'b0;
    assign mem_b_addr  = r0_gnt ? r0_addr : r1_gnt ? r1_addr : '0;
    assign mem_b_wdata = r0_gnt ? r0_wdata : r1_gnt ? r1_wdata : '0;

    // Gating with reset drops a read whose response would land in a reset cycle.
    assign r0_rvalid = rpend0 && !reset;
    assign r1_rvalid = rpend1 && !reset;
    assign r0_rdata  = mem_b_rdata;
    assign r1_rdata  = mem_b_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner  <= 1'b0;
            last   <= 1'b1;
            beats  <= '0;
            rpend0 <= 1'b0;
            rpend1 <= 1'b0;
        end else begin
            rpend0 <= r0_gnt && !r0_we;
            rpend1 <= r1_gnt && !r1_we;
            if (r0_gnt || r1_gnt) begin
                last <= r1_gnt;
                if (r1_gnt == owner) begin
                    beats <= (beats == BW'(MAX_BURST)) ? beats : beats + 1'b1;
                end else begin
                    owner <= r1_gnt;
                    beats <= BW'(1);
                end
            end else begin
                beats <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// tb_mem_port_b_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
module tb_mem_port_b_arbiter;
    localparam int MAXB = 4;

    logic        clk, reset;
    logic        r0_req, r0_we, r0_gnt, r0_rvalid;
    logic [15:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_rvalid;
    logic [15:0] r1_addr, r1_wdata, r1_rdata;
    logic [15:0] mem_b_addr, mem_b_wdata, mem_b_rdata;
    logic        mem_b_we;

    int checks = 0;
    int errors = 0;

    mem_port_b_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_b_addr(mem_b_addr), .mem_b_wdata(mem_b_wdata), .mem_b_we(mem_b_we),
        .mem_b_rdata(mem_b_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM standing in for port B (256 words are enough for the stimulus).
    logic [15:0] bram [0:255] = '{default: 16'h0};
    always @(posedge clk) begin
        if (mem_b_we) bram[mem_b_addr[7:0]] <= mem_b_wdata;
        mem_b_rdata <= bram[mem_b_addr[7:0]];
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endtask

    // Behavioural model: who currently holds the port, how long their run is,
    // who won most recently, and what each pending read must return.
    bit          hold, prev, mp0, mp1, w0, w1, g0q, g1q, hreq, oreq, ew;
    int          run;
    logic [15:0] erd0, erd1, ea, ed;
    logic [15:0] mram [0:255];

    initial begin
        for (int i = 0; i < 256; i++) mram[i] = 16'h0;
        hold = 0; prev = 1; run = 0; mp0 = 0; mp1 = 0; g0q = 0; g1q = 0;
        forever begin
            @(negedge clk);
            w0 = 0;
            w1 = 0;
            if (!reset) begin
                hreq = hold ? r1_req : r0_req;
                oreq = hold ? r0_req : r1_req;
                if (hreq && (run < MAXB || !oreq)) begin w0 = !hold; w1 = hold; end
                else if (r0_req && r1_req) begin w0 = prev; w1 = !prev; end
                else begin w0 = r0_req; w1 = r1_req; end
            end
            ew = w0 ? r0_we : w1 ? r1_we : 1'b0;
            ea = w0 ? r0_addr : w1 ? r1_addr : 16'h0;
            ed = w0 ? r0_wdata : w1 ? r1_wdata : 16'h0;
            chk("gnt0", r0_gnt, w0);
            chk("gnt1", r1_gnt, w1);
            chk("one_hot", r0_gnt && r1_gnt, 0);
            chk("mem_we", mem_b_we, ew);
            chk("mem_addr", mem_b_addr, ea);
            chk("mem_wdata", mem_b_wdata, ed);
            chk("rvalid0", r0_rvalid, mp0 && !reset);
            chk("rvalid1", r1_rvalid, mp1 && !reset);
            if (mp0 && !reset) chk("rdata0", r0_rdata, erd0);
            if (mp1 && !reset) chk("rdata1", r1_rdata, erd1);
            if (reset) begin
                hold = 0; prev = 1; run = 0; mp0 = 0; mp1 = 0;
            end else begin
                mp0 = w0 && !r0_we;
                mp1 = w1 && !r1_we;
                if (mp0) erd0 = mram[r0_addr[7:0]];
                if (mp1) erd1 = mram[r1_addr[7:0]];
                if (ew) mram[ea[7:0]] = ed;
                if (w0 || w1) begin
                    prev = w1;
                    if (w1 == hold) run = (run < MAXB) ? run + 1 : MAXB;
                    else begin hold = w1; run = 1; end
                end else run = 0;
            end
            g0q = w0;
            g1q = w1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic rq, input logic we, input logic [15:0] a, input logic [15:0] d);
        r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set1(input logic rq, input logic we, input logic [15:0] a, input logic [15:0] d);
        r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = d;
    endtask

    initial begin
        reset = 1;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        set0(1, 0, 16'h0001, 0);
        set1(1, 0, 16'h0002, 0);
        @(negedge clk);
        chk("t1_gnt0", r0_gnt, 0);
        chk("t1_gnt1", r1_gnt, 0);
        chk("t1_we", mem_b_we, 0);
        step();
        reset = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t3_gnt0", r0_gnt, (i < 4 || i >= 8) ? 1 : 0);
            chk("t3_gnt1", r1_gnt, (i >= 4 && i < 8) ? 1 : 0);
            step();
        end
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        step();
        set0(1, 1, 16'h0010, 16'hBEEF);
        @(negedge clk);
        chk("t2_wgnt0", r0_gnt, 1);
        step();
        set0(0, 0, 0, 0);
        set1(1, 0, 16'h0010, 0);
        @(negedge clk);
        chk("t2_gnt1", r1_gnt, 1);
        step();
        set1(0, 0, 0, 0);
        @(negedge clk);
        chk("t2_rvalid1", r1_rvalid, 1);
        chk("t2_rdata1", r1_rdata, 16'hBEEF);
        chk("t2_rvalid0", r0_rvalid, 0);
        step();
        set0(1, 1, 16'h0040, 16'h1234);
        @(negedge clk);
        chk("t5_wgnt0", r0_gnt, 1);
        step();
        set0(0, 0, 0, 0);
        set1(1, 0, 16'h0040, 0);
        @(negedge clk);
        chk("t5_gnt1", r1_gnt, 1);
        step();
        set1(0, 0, 0, 0);
        @(negedge clk);
        chk("t5_rvalid1", r1_rvalid, 1);
        chk("t5_rdata1", r1_rdata, 16'h1234);
        step();
        set0(1, 0, 16'h0005, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_gnt0", r0_gnt, 1);
            step();
        end
        set1(1, 0, 16'h0006, 0);
        @(negedge clk);
        chk("t4_gnt1", r1_gnt, 1);
        chk("t4_gnt0_off", r0_gnt, 0);
        step();
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        step();
        set0(1, 0, 16'h0007, 0);
        @(negedge clk);
        chk("t6_gnt0", r0_gnt, 1);
        step();
        reset = 1;
        set0(0, 0, 0, 0);
        @(negedge clk);
        chk("t6_rvalid_n1", r0_rvalid, 0);
        step();
        reset = 0;
        @(negedge clk);
        chk("t6_rvalid_n2", r0_rvalid, 0);
        repeat (3000) begin
            step();
            reset = ($urandom_range(0, 63) == 0);
            if (!r0_req || g0q)
                set0($urandom_range(0, 2) != 0, 1'($urandom), 16'($urandom_range(0, 255)), 16'($urandom));
            if (!r1_req || g1q)
                set1($urandom_range(0, 2) != 0, 1'($urandom), 16'($urandom_range(0, 255)), 16'($urandom));
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
